// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read command generator.
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WAIT_DONE
    } rd_state_t;

    localparam logic [2:0]  APP_CMD_RD     = 3'b001;
    localparam int unsigned BEATS_PER_UNIT = 4;
    localparam int unsigned XFER_CNT_W     = 34;

    localparam int unsigned CFG_N_MSB    = 63;
    localparam int unsigned CFG_N_LSB    = 32;
    localparam int unsigned CFG_ADDR_MSB = 31;
    localparam int unsigned CFG_ADDR_LSB = 0;

    // Full-width product so a 32-bit unit count never truncates.
    function automatic logic [XFER_CNT_W-1:0] units_to_cmds(input logic [31:0] n);
        return XFER_CNT_W'(n) * XFER_CNT_W'(BEATS_PER_UNIT);
    endfunction

endpackage

// File: rtl/ddr_rd_outstanding_cnt.sv
// Up/down count of read commands accepted by the MIG but not yet returned.
module ddr_rd_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic ddr_user_clk,
    input  logic ddr_user_rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic at_limit,
    output logic is_zero
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count;

    // A stray return beat with nothing outstanding must not wrap the count.
    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst || clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign at_limit = (count >= CNT_W'(MAX_OUTSTANDING));
    assign is_zero  = (count == '0);

endmodule

// File: rtl/ddr_rd_cmd_gen.sv
// Issues 4*N sequential MIG read commands per start and forwards returned data.
// Optional watchdog abort is compiled in with DDR_RD_TIMEOUT_EN.
module ddr_rd_cmd_gen
    import ddr_rd_pkg::*;
#(
    parameter int unsigned ADDR_W          = 29,
    parameter int unsigned ADDR_STEP       = 8,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
    input  logic              ddr_user_clk,
    input  logic              ddr_user_rst,
    input  logic              ddr_to_mac_start,
    input  logic [63:0]       I_cfg_value_rd_ddr,
    input  logic              ddr_to_mac_rd_en,
    input  logic              ddr_to_mac_done,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [127:0]      ddr_to_mac_data,
    output logic              ddr_to_mac_data_valid,
    output logic              busy,
    output logic              zero_len_err,
    output logic              timeout_err
);

    rd_state_t             state, state_nxt;
    logic [XFER_CNT_W-1:0] cmd_total, issued, returned;
    logic [ADDR_W-1:0]     addr;
    logic [31:0]           cfg_n;
    logic                  out_at_limit, out_zero;
    logic                  cmd_accept, start_ok, wd_expire;

    assign cfg_n = I_cfg_value_rd_ddr[CFG_N_MSB:CFG_N_LSB];

    if (ADDR_W < 32) begin : g_addr_trunc
        logic cfg_addr_unused;
        assign cfg_addr_unused = ^I_cfg_value_rd_ddr[CFG_ADDR_MSB:ADDR_W];
    end

`ifdef DDR_RD_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    localparam int unsigned wd_limit_unused = TIMEOUT_CYCLES;
`endif

    assign app_en = !ddr_user_rst && (state == ST_ISSUE) && ddr_to_mac_rd_en &&
                    !out_at_limit && (issued < cmd_total);
    assign cmd_accept = app_en && app_rdy;
    assign start_ok   = (state == ST_IDLE) && ddr_to_mac_start && (cfg_n != '0);
    assign app_cmd    = APP_CMD_RD;
    assign app_addr   = addr;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (start_ok) state_nxt = ST_ISSUE;
            ST_ISSUE:     if (cmd_accept && (issued == cmd_total - 1'b1)) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (ddr_to_mac_done)                        state_nxt = ST_IDLE;
                else if (out_zero && (returned == cmd_total)) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (ddr_to_mac_done) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
`ifdef DDR_RD_TIMEOUT_EN
        // Expiry is judged against the un-aborted next state so a normal move counts as activity.
        wd_expire = busy && !cmd_accept && !app_rd_data_valid && (state_nxt == state) &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
        if (wd_expire) state_nxt = ST_IDLE;
`else
        wd_expire = 1'b0;
`endif
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            state        <= ST_IDLE;
            cmd_total    <= '0;
            issued       <= '0;
            returned     <= '0;
            addr         <= '0;
            zero_len_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            zero_len_err <= (state == ST_IDLE) && ddr_to_mac_start && (cfg_n == '0);
            if (wd_expire) begin
                issued   <= '0;
                returned <= '0;
            end else if (start_ok) begin
                cmd_total <= units_to_cmds(cfg_n);
                addr      <= I_cfg_value_rd_ddr[CFG_ADDR_LSB +: ADDR_W];
                issued    <= '0;
                returned  <= '0;
            end else begin
                if (cmd_accept) begin
                    issued <= issued + 1'b1;
                    addr   <= addr + ADDR_W'(ADDR_STEP);
                end
                if (app_rd_data_valid && ((state == ST_ISSUE) || (state == ST_DRAIN)))
                    returned <= returned + 1'b1;
            end
        end
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            ddr_to_mac_data       <= '0;
            ddr_to_mac_data_valid <= 1'b0;
        end else begin
            ddr_to_mac_data       <= app_rd_data;
            ddr_to_mac_data_valid <= app_rd_data_valid;
        end
    end

`ifdef DDR_RD_TIMEOUT_EN
    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst || !busy || cmd_accept || app_rd_data_valid ||
            (state_nxt != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) timeout_err <= 1'b0;
        else              timeout_err <= wd_expire;
    end
`else
    assign timeout_err = 1'b0;
`endif

    ddr_rd_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .ddr_user_clk (ddr_user_clk),
        .ddr_user_rst (ddr_user_rst),
        .clr          (wd_expire),
        .inc          (cmd_accept),
        .dec          (app_rd_data_valid),
        .at_limit     (out_at_limit),
        .is_zero      (out_zero)
    );

endmodule
